interrupt_controller: RTL

//   Prioritising interrupt controller between the board-level interrupt lines and core0.

---
 rtl/interrupt_controller_if.sv | 19 +
 rtl/interrupt_controller.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller_if.sv
// Core-side bundle of the interrupt controller: configuration register port
// plus the irq/ack/eoi handshake towards core0.
interface interrupt_controller_if #(
  parameter int CODE_W = 3
);
  logic              cfg_we;
  logic [1:0]        cfg_addr;
  logic [31:0]       cfg_wdata;
  logic [31:0]       cfg_rdata;
  logic              o_irq;
  logic [CODE_W-1:0] o_irq_code;
  logic              i_irq_ack;
  logic              i_eoi;

  modport master (output cfg_we, cfg_addr, cfg_wdata, i_irq_ack, i_eoi,
                  input  cfg_rdata, o_irq, o_irq_code);
  modport slave  (input  cfg_we, cfg_addr, cfg_wdata, i_irq_ack, i_eoi,
                  output cfg_rdata, o_irq, o_irq_code);
endinterface

// File: rtl/interrupt_controller.sv
// Prioritising interrupt controller (index 0 = highest priority) for core0.
// Optional nested preemption with an in-service stack when INTC_NESTING_EN is defined.
module interrupt_controller #(
  parameter int N_SRC  = 5,
  parameter int CODE_W = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_SRC-1:0]     i_interruption,
  interrupt_controller_if.slave bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  localparam logic [1:0] A_MASK = 2'd0;
  localparam logic [1:0] A_EDGE = 2'd1;
  localparam logic [1:0] A_PEND = 2'd2;

  logic [N_SRC-1:0]  sync1_q, sync2_q, s2_prev_q;
  logic [N_SRC-1:0]  mask_q, mask_d;
  logic [N_SRC-1:0]  edge_q, edge_d;
  logic [N_SRC-1:0]  pend_q, pend_d;
  logic [1:0]        state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;

  logic [N_SRC-1:0]  rise, avail, wr_clr, ack_clr, code_sel;
  logic              ack_take, eoi_take, code_live;
  logic              in_svc, last_svc, preempt;
  logic [CODE_W-1:0] svc_code;
  logic [31:0]       status;
  logic              unused_wdata;

  function automatic logic [CODE_W-1:0] lowest_idx(input logic [N_SRC-1:0] v);
    lowest_idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (v[i]) lowest_idx = CODE_W'(i);
  endfunction

  assign unused_wdata = ^bus.cfg_wdata[31:N_SRC];

  assign rise     = sync2_q & ~s2_prev_q;
  assign avail    = pend_q & mask_q;
  assign ack_take = (state_q == ST_REQ) && bus.i_irq_ack;
  assign eoi_take = (state_q == ST_SERVICE) && bus.i_eoi;
  assign wr_clr   = (bus.cfg_we && bus.cfg_addr == A_PEND) ? bus.cfg_wdata[N_SRC-1:0] : '0;

  always_comb begin
    code_sel = '0;
    for (int i = 0; i < N_SRC; i++)
      code_sel[i] = (code_q == CODE_W'(i));
  end

  assign ack_clr   = ack_take ? code_sel : '0;
  assign code_live = |(avail & code_sel);

`ifdef INTC_NESTING_EN
  localparam int DEPTH_W = $clog2(N_SRC + 1);
  localparam int IDX_W   = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [CODE_W-1:0]  stk_q [N_SRC];
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [N_SRC-1:0]   above;

  assign in_svc   = (depth_q != '0);
  assign svc_code = in_svc ? stk_q[IDX_W'(depth_q - DEPTH_W'(1))] : '0;
  assign last_svc = (depth_q == DEPTH_W'(1));

  // Only strictly higher-priority sources than the top of stack may preempt.
  always_comb begin
    above = '0;
    for (int i = 0; i < N_SRC; i++)
      above[i] = (CODE_W'(i) < svc_code);
  end

  assign preempt = in_svc && |(avail & above);

  always_comb begin
    depth_d = depth_q;
    if (ack_take)      depth_d = depth_q + DEPTH_W'(1);
    else if (eoi_take) depth_d = depth_q - DEPTH_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) depth_q <= '0;
    else        depth_q <= depth_d;
  end

  always_ff @(posedge clk) begin
    if (ack_take) stk_q[IDX_W'(depth_q)] <= code_q;
  end
`else
  assign in_svc   = (state_q == ST_SERVICE);
  assign svc_code = in_svc ? code_q : '0;
  assign last_svc = 1'b1;
  assign preempt  = 1'b0;
`endif

  // Edge-mode bits: a new rising edge wins over a same-cycle clear.
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < N_SRC; i++)
      pend_d[i] = edge_q[i] ? (rise[i] | (pend_q[i] & ~(wr_clr[i] | ack_clr[i])))
                            : sync2_q[i];
    mask_d = mask_q;
    edge_d = edge_q;
    if (bus.cfg_we && bus.cfg_addr == A_MASK) mask_d = bus.cfg_wdata[N_SRC-1:0];
    if (bus.cfg_we && bus.cfg_addr == A_EDGE) edge_d = bus.cfg_wdata[N_SRC-1:0];
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    case (state_q)
      ST_IDLE: begin
        if (|avail) begin
          code_d  = lowest_idx(avail);
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (ack_take)        state_d = ST_SERVICE;
        else if (!code_live) state_d = in_svc ? ST_SERVICE : ST_IDLE;
      end
      ST_SERVICE: begin
        if (eoi_take) begin
          state_d = last_svc ? ST_IDLE : ST_SERVICE;
        end else if (preempt) begin
          code_d  = lowest_idx(avail);
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    status              = '0;
    status[8]           = in_svc;
    status[CODE_W-1:0]  = svc_code;
    case (bus.cfg_addr)
      A_MASK:  bus.cfg_rdata = 32'(mask_q);
      A_EDGE:  bus.cfg_rdata = 32'(edge_q);
      A_PEND:  bus.cfg_rdata = 32'(pend_q);
      default: bus.cfg_rdata = status;
    endcase
  end

  assign bus.o_irq      = (state_q == ST_REQ);
  assign bus.o_irq_code = code_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      s2_prev_q <= '0;
      mask_q    <= '0;
      edge_q    <= '0;
      pend_q    <= '0;
      state_q   <= ST_IDLE;
      code_q    <= '0;
    end else begin
      sync1_q   <= i_interruption;
      sync2_q   <= sync1_q;
      s2_prev_q <= sync2_q;
      mask_q    <= mask_d;
      edge_q    <= edge_d;
      pend_q    <= pend_d;
      state_q   <= state_d;
      code_q    <= code_d;
    end
  end

endmodule
